pz_bank_scheduler: RTL and testbench
====================================

// Module: pz_bank_scheduler
// PURPOSE
//  Double-buffered pole/zero configuration scheduler for the pixel datapath.
//  Config writes land in a shadow bank. A commit request is deferred until the
//  next frame boundary, where banks swap atomically. The complex_sub array and
//  pz_accumulator therefore see one consistent pole/zero set and no_z/no_p
//  count for every frame.
//  After each swap, the block copies the new active bank into the new shadow
//  bank, so incremental edits start from the live set.
// PARAMETERS
//  REG_FILE_SIZE   8   number of pole/zero entries per bank (AW = $clog2(REG_FILE_SIZE))
//  CNT_WIDTH       32  width of no_z / no_p counts (matches pz_accumulator)
//  FCNT_WIDTH      16  width of frame counter
// PORTS
//  out_stream_aclk     in   1            sole clock
//  periph_resetn       in   1            asynchronous, active-low reset
//  cfg_wvalid          in   1            shadow-bank write request
//  cfg_wready          out  1            write accepted when wvalid&&wready
//  cfg_waddr           in   AW+1         entry index; >= REG_FILE_SIZE is out of range
//  cfg_wdata           in   32           {re[31:16], im[15:0]} signed Q-format word
//  cfg_werr            out  1            1-cycle pulse: accepted write was out of range
//  cfg_commit          in   1            request swap at next frame boundary
//  cfg_no_z, cfg_no_p  in   CNT_WIDTH    counts sampled when commit is accepted
//  commit_pending      out  1            commit accepted, swap not yet done
//  frame_end           in   1            high the cycle the last coordinate of a frame is accepted
//  active_pz           out  32*REG_FILE_SIZE  flat active bank, entry i at [32*i +: 32]
//  active_no_z/no_p    out  CNT_WIDTH    active counts
//  swap_done           out  1            1-cycle pulse, cycle after a swap
//  frame_count         out  FCNT_WIDTH   count of frame_end events
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - both banks all 0; active_sel = 0; active_no_z = 1; active_no_p = 0.
//   - shadow counts = 1/0; state = IDLE; frame_count = 0.
//   - cfg_werr, swap_done, commit_pending = 0.
//   - Reset mid-operation discards any pending commit or partial copy.
//  FSM states: IDLE, PENDING, COPY. cfg_wready = (state==IDLE).
//  IDLE:
//   - Accepted in-range write updates shadow[cfg_waddr] at the clock edge.
//   - Out-of-range write is accepted and dropped; cfg_werr pulses the next cycle.
//   - cfg_commit=1: latch cfg_no_z/no_p into shadow counts, then go to PENDING.
//   - Write and commit in the same cycle: the write is included in the commit.
//  PENDING:
//   - commit_pending=1; writes stalled (wready=0); cfg_commit ignored.
//   - On frame_end: toggle active_sel, load active counts from shadow counts,
//     reset copy index to 0, go to COPY.
//   - active_pz and counts change on the edge sampling frame_end, so they are
//     valid from the first coordinate of the next frame.
//   - swap_done pulses on the following cycle.
//  COPY:
//   - One entry per cycle: shadow[idx] <= active[idx], idx 0..REG_FILE_SIZE-1.
//   - Exactly REG_FILE_SIZE cycles, then IDLE; wready=0 throughout.
//   - frame_end in COPY: no swap, counter only.
//  frame_count increments on every frame_end in any state and wraps at 2^FCNT_WIDTH.
//  active_pz is a direct register read of the active bank; no combinational
//  path from cfg_* to active_*.
//  Commit with no intervening writes is legal; it swaps identical contents.
// TESTING
//  1. Reset -> active_pz=0, active_no_z=1, active_no_p=0, cfg_wready=1,
//     frame_count=0, all pulses 0.
//  2. Write idx2=0x0100_FF00, commit(no_z=1,no_p=1) -> active unchanged,
//     commit_pending=1 until frame_end; then active_pz[95:64]=0x0100FF00,
//     no_p=1, swap_done 1 cycle later.
//  3. After swap -> cfg_wready=0 for exactly 8 cycles. Then write idx0 only,
//     commit, frame_end -> idx2 still 0x0100FF00 (copy-back verified).
//  4. Write to idx 9 -> accepted, cfg_werr pulses once, no bank entry changes.
//  5. Commit in cycle t, frame_end in t+1 -> swap at t+1. frame_end while IDLE
//     -> frame_count+1, no swap. Write+commit in same cycle -> write visible
//     after swap.
//  6. Assert periph_resetn low mid-COPY (idx=3) -> immediate reset state; a
//     later frame_end causes no swap.

Source files
------------

// File: rtl/pz_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pz_bank_scheduler
// Purpose  : Double-buffered pole/zero configuration scheduler. Config writes
//            land in the shadow bank. A commit is held until the next frame
//            boundary, where the banks swap atomically. Afterwards the new
//            active bank is copied back into the new shadow bank, one entry
//            per cycle, so incremental edits start from the live set.
// Ports    : out_stream_aclk / periph_resetn    clock, async active-low reset
//            cfg_wvalid/wready/waddr/wdata      shadow-bank write channel
//            cfg_werr                           pulse: write was out of range
//            cfg_commit, cfg_no_z, cfg_no_p     commit request and counts
//            commit_pending, swap_done          commit / swap status
//            frame_end                          last coordinate of a frame
//            active_pz, active_no_z/no_p        live pole/zero set and counts
//            frame_count                        wrapping frame_end counter
// Revision : 1.0 - initial release
// ============================================================================
module pz_bank_scheduler #(
    parameter int REG_FILE_SIZE = 8,
    parameter int CNT_WIDTH     = 32,
    parameter int FCNT_WIDTH    = 16,
    localparam int AW           = $clog2(REG_FILE_SIZE)
) (
    input  logic                       out_stream_aclk,
    input  logic                       periph_resetn,
    input  logic                       cfg_wvalid,
    output logic                       cfg_wready,
    input  logic [AW:0]                cfg_waddr,
    input  logic [31:0]                cfg_wdata,
    output logic                       cfg_werr,
    input  logic                       cfg_commit,
    input  logic [CNT_WIDTH-1:0]       cfg_no_z,
    input  logic [CNT_WIDTH-1:0]       cfg_no_p,
    output logic                       commit_pending,
    input  logic                       frame_end,
    output logic [32*REG_FILE_SIZE-1:0] active_pz,
    output logic [CNT_WIDTH-1:0]       active_no_z,
    output logic [CNT_WIDTH-1:0]       active_no_p,
    output logic                       swap_done,
    output logic [FCNT_WIDTH-1:0]      frame_count
);

    localparam logic [1:0]    c_ST_IDLE    = 2'd0;
    localparam logic [1:0]    c_ST_PENDING = 2'd1;
    localparam logic [1:0]    c_ST_COPY    = 2'd2;
    localparam logic [AW:0]   c_SIZE       = (AW+1)'(REG_FILE_SIZE);
    localparam logic [AW-1:0] c_LAST_IDX   = AW'(REG_FILE_SIZE - 1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic                 r_active_sel;
    logic [AW-1:0]        r_copy_idx;
    logic [31:0]          r_bank [2][REG_FILE_SIZE];
    logic [CNT_WIDTH-1:0] r_shadow_no_z;
    logic [CNT_WIDTH-1:0] r_shadow_no_p;
    logic [CNT_WIDTH-1:0] r_active_no_z;
    logic [CNT_WIDTH-1:0] r_active_no_p;
    logic                 r_werr;
    logic                 r_swap_done;
    logic [FCNT_WIDTH-1:0] r_frame_count;

    logic w_wr_accept;
    logic w_wr_in_range;
    logic w_commit;
    logic w_swap;
    logic w_copy;

    assign w_wr_accept   = (r_state == c_ST_IDLE) && cfg_wvalid;
    assign w_wr_in_range = (cfg_waddr < c_SIZE);
    assign w_commit      = (r_state == c_ST_IDLE) && cfg_commit;
    assign w_swap        = (r_state == c_ST_PENDING) && frame_end;
    assign w_copy        = (r_state == c_ST_COPY);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:    if (cfg_commit) w_state_next = c_ST_PENDING;
            c_ST_PENDING: if (frame_end) w_state_next = c_ST_COPY;
            c_ST_COPY:    if (r_copy_idx == c_LAST_IDX) w_state_next = c_ST_IDLE;
            default:      w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Bank storage. The shadow bank is always the one not selected by
    // r_active_sel; during COPY the select has already toggled, so the
    // copy reads the freshly activated bank into the old one.
    // ------------------------------------------------------------------
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < REG_FILE_SIZE; i++) begin
                    r_bank[b][i] <= 32'd0;
                end
            end
        end else begin
            if (w_wr_accept && w_wr_in_range) begin
                r_bank[~r_active_sel][cfg_waddr[AW-1:0]] <= cfg_wdata;
            end
            if (w_copy) begin
                r_bank[~r_active_sel][r_copy_idx] <= r_bank[r_active_sel][r_copy_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Counts, select, copy index, status pulses, frame counter
    // ------------------------------------------------------------------
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            r_active_sel  <= 1'b0;
            r_copy_idx    <= '0;
            r_shadow_no_z <= CNT_WIDTH'(1);
            r_shadow_no_p <= '0;
            r_active_no_z <= CNT_WIDTH'(1);
            r_active_no_p <= '0;
            r_werr        <= 1'b0;
            r_swap_done   <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_werr      <= w_wr_accept && !w_wr_in_range;
            r_swap_done <= w_swap;
            if (frame_end) begin
                r_frame_count <= r_frame_count + FCNT_WIDTH'(1);
            end
            if (w_commit) begin
                r_shadow_no_z <= cfg_no_z;
                r_shadow_no_p <= cfg_no_p;
            end
            if (w_swap) begin
                r_active_sel  <= ~r_active_sel;
                r_active_no_z <= r_shadow_no_z;
                r_active_no_p <= r_shadow_no_p;
                r_copy_idx    <= '0;
            end else if (w_copy) begin
                r_copy_idx    <= r_copy_idx + AW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: active set is a register read only, never from cfg_*
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < REG_FILE_SIZE; gi++) begin : g_active
        assign active_pz[32*gi +: 32] = r_bank[r_active_sel][gi];
    end

    assign cfg_wready     = (r_state == c_ST_IDLE);
    assign commit_pending = (r_state == c_ST_PENDING);
    assign cfg_werr       = r_werr;
    assign swap_done      = r_swap_done;
    assign active_no_z    = r_active_no_z;
    assign active_no_p    = r_active_no_p;
    assign frame_count    = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_pz_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pz_bank_scheduler
// Purpose  : Self-checking bench for pz_bank_scheduler. A transaction-level
//            model (live set, edit set, pending flag, busy countdown) is
//            compared against the DUT every cycle, plus literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pz_bank_scheduler;

    localparam int N  = 8;
    localparam int CW = 32;
    localparam int FW = 16;
    localparam int AW = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wvalid;
    logic             wready;
    logic [AW:0]      waddr;
    logic [31:0]      wdata;
    logic             werr;
    logic             commit;
    logic [CW-1:0]    no_z;
    logic [CW-1:0]    no_p;
    logic             pending;
    logic             frame_end;
    logic [32*N-1:0]  active_pz;
    logic [CW-1:0]    act_z;
    logic [CW-1:0]    act_p;
    logic             swap_done;
    logic [FW-1:0]    fcount;

    always #5 clk = ~clk;

    pz_bank_scheduler #(
        .REG_FILE_SIZE (N),
        .CNT_WIDTH     (CW),
        .FCNT_WIDTH    (FW)
    ) u_dut (
        .out_stream_aclk (clk),
        .periph_resetn   (rst_n),
        .cfg_wvalid      (wvalid),
        .cfg_wready      (wready),
        .cfg_waddr       (waddr),
        .cfg_wdata       (wdata),
        .cfg_werr        (werr),
        .cfg_commit      (commit),
        .cfg_no_z        (no_z),
        .cfg_no_p        (no_p),
        .commit_pending  (pending),
        .frame_end       (frame_end),
        .active_pz       (active_pz),
        .active_no_z     (act_z),
        .active_no_p     (act_p),
        .swap_done       (swap_done),
        .frame_count     (fcount)
    );

    int checks   = 0;
    int failures = 0;
    int n_fe     = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: the live set and the edit set. After a swap both hold the
    // same contents, so the copy-back needs no explicit modelling; only
    // its duration (N busy cycles) is visible.
    // ------------------------------------------------------------------
    logic [31:0]   m_live [N];
    logic [31:0]   m_edit [N];
    logic [CW-1:0] m_live_z, m_live_p, m_edit_z, m_edit_p;
    bit            m_pend;
    int            m_busy;
    logic [FW-1:0] m_fc;
    bit            m_werr, m_swap;

    function automatic logic [255:0] live_vec();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[32*i +: 32] = m_live[i];
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_live[i] = 32'd0;
                m_edit[i] = 32'd0;
            end
            m_live_z = 1; m_live_p = 0; m_edit_z = 1; m_edit_p = 0;
            m_pend = 0; m_busy = 0; m_fc = 0; m_werr = 0; m_swap = 0;
        end else begin
            m_werr = 0;
            m_swap = 0;
            if (frame_end) m_fc = m_fc + 1'b1;
            if (m_busy > 0) begin
                m_busy = m_busy - 1;
            end else if (m_pend) begin
                if (frame_end) begin
                    m_live   = m_edit;
                    m_live_z = m_edit_z;
                    m_live_p = m_edit_p;
                    m_pend   = 0;
                    m_busy   = N;
                    m_swap   = 1;
                end
            end else begin
                if (wvalid) begin
                    if (int'(waddr) < N) m_edit[waddr[AW-1:0]] = wdata;
                    else m_werr = 1;
                end
                if (commit) begin
                    m_edit_z = no_z;
                    m_edit_p = no_p;
                    m_pend   = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_wready",    wready,    (m_busy == 0) && !m_pend);
            check("cyc_pending",   pending,   m_pend);
            check("cyc_werr",      werr,      m_werr);
            check("cyc_swap_done", swap_done, m_swap);
            check("cyc_active_pz", active_pz, live_vec());
            check("cyc_no_z",      act_z,     m_live_z);
            check("cyc_no_p",      act_p,     m_live_p);
            check("cyc_fcount",    fcount,    m_fc);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all return at posedge + 1)
    // ------------------------------------------------------------------
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW:0] a, input logic [31:0] d);
        wvalid = 1'b1; waddr = a; wdata = d;
        sync();
        wvalid = 1'b0;
    endtask

    task automatic do_commit(input logic [CW-1:0] z, input logic [CW-1:0] p);
        commit = 1'b1; no_z = z; no_p = p;
        sync();
        commit = 1'b0;
    endtask

    task automatic do_frame();
        frame_end = 1'b1;
        sync();
        frame_end = 1'b0;
        n_fe++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [255:0] exp_vec;
        int busy_cycles;
        int werr_seen;

        rst_n = 1'b0; wvalid = 1'b0; waddr = '0; wdata = '0;
        commit = 1'b0; no_z = '0; no_p = '0; frame_end = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // 1. reset state
        @(negedge clk);
        check("rst_active_pz", active_pz, 256'd0);
        check("rst_no_z",      act_z,     1);
        check("rst_no_p",      act_p,     0);
        check("rst_wready",    wready,    1);
        check("rst_fcount",    fcount,    0);
        check("rst_pulses",    {werr, swap_done, pending}, 0);
        sync();

        // 2. write idx2, commit, hold pending until frame_end
        do_write(4'd2, 32'h0100_FF00);
        do_commit(1, 1);
        repeat (3) sync();
        check("t2_pending",   pending,   1);
        check("t2_unchanged", active_pz, 256'd0);
        do_frame();
        check("t2_idx2",      active_pz[95:64], 32'h0100_FF00);
        check("t2_no_p",      act_p, 1);
        check("t2_swap_done", swap_done, 1);

        // 3. wready low for exactly N cycles, then copy-back check
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!wready) busy_cycles++;
            else break;
        end
        check("t3_busy_cycles", busy_cycles, 8);
        sync();
        do_write(4'd0, 32'h1234_5678);
        do_commit(3, 2);
        do_frame();
        check("t3_idx2_kept", active_pz[95:64], 32'h0100_FF00);
        check("t3_idx0",      active_pz[31:0],  32'h1234_5678);
        check("t3_no_z",      act_z, 3);
        repeat (10) sync();

        // 4. out-of-range writes: accepted, flagged, dropped
        werr_seen = 0;
        do_write(4'd9, 32'hDEAD_BEEF);
        if (werr) werr_seen++;
        sync();
        if (werr) werr_seen++;
        check("t4_werr_once", werr_seen, 1);
        do_write(4'd8, 32'hCAFE_F00D);
        check("t4_werr_idx8", werr, 1);
        do_commit(3, 2);
        do_frame();
        exp_vec = '0;
        exp_vec[31:0]  = 32'h1234_5678;
        exp_vec[95:64] = 32'h0100_FF00;
        check("t4_bank_intact", active_pz, exp_vec);
        repeat (10) sync();

        // 5. commit at t, frame_end at t+1; idle frame_end; write+commit
        do_commit(1, 0);
        do_frame();
        check("t5_fast_swap", swap_done, 1);
        check("t5_no_z",      act_z, 1);
        repeat (10) sync();
        do_frame();
        check("t5_idle_fcount", fcount, n_fe);
        check("t5_idle_noswap", swap_done, 0);
        wvalid = 1'b1; waddr = 4'd5; wdata = 32'hA5A5_5A5A;
        commit = 1'b1; no_z = 4; no_p = 4;
        sync();
        wvalid = 1'b0; commit = 1'b0;
        do_frame();
        check("t5_wr_commit", active_pz[191:160], 32'hA5A5_5A5A);
        repeat (10) sync();

        // 6. reset in the middle of the copy (idx 3)
        do_write(4'd7, 32'h7777_7777);
        do_commit(2, 2);
        do_frame();
        repeat (3) sync();
        rst_n = 1'b0;
        n_fe = 0;
        #1;
        check("t6_rst_active", active_pz, 256'd0);
        check("t6_rst_no_z",   act_z, 1);
        check("t6_rst_wready", wready, 1);
        check("t6_rst_fcount", fcount, 0);
        sync();
        sync();
        rst_n = 1'b1;
        sync();
        do_frame();
        check("t6_no_swap",   swap_done, 0);
        check("t6_fcount",    fcount, n_fe);
        sync();
        check("t6_still_zero", active_pz, 256'd0);

        repeat (2) sync();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
